// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters; one op in flight.
// Latency: accept edge -> rsp_valid after ALU_LAT more edges (illegal op: on the accept edge).
// Backpressure: response holds while rsp_ready=0; no new grant until the response is consumed.
module alu_req_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_c,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_c,
    output logic [5:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_c,
    input  logic [31:0] alu_res,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_res,
    output logic        rsp_carry,
    output logic        rsp_z,
    output logic        rsp_n,
    output logic        rsp_err
);

    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_EQ  = 6'b100000;
    localparam logic [5:0] OP_LLS = 6'b110000;
    localparam logic [5:0] OP_LRS = 6'b110001;
    localparam logic [5:0] OP_ARS = 6'b110010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        ptr;
    logic [3:0]  cnt;

    logic        gnt_vld;
    logic        gnt_id;
    logic [5:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_c;
    logic        sel_legal;
    logic        cur_arith;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_EQ) ||
               (op == OP_LLS) || (op == OP_LRS) || (op == OP_ARS);
    endfunction

    // Arbitration: sole valid requester wins, a tie goes to the priority pointer.
    always_comb begin
        gnt_vld    = req0_valid | req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? ptr : req1_valid;
        req0_ready = rst_n && (state == IDLE) && gnt_vld && !gnt_id;
        req1_ready = rst_n && (state == IDLE) && gnt_vld && gnt_id;
        sel_op     = gnt_id ? req1_op : req0_op;
        sel_a      = gnt_id ? req1_a  : req0_a;
        sel_b      = gnt_id ? req1_b  : req0_b;
        sel_c      = gnt_id ? req1_c  : req0_c;
        sel_legal  = op_legal(sel_op);
        cur_arith  = (alu_op == OP_ADD) || (alu_op == OP_SUB);
    end

    // Next-state: illegal ops skip EXEC; RESP waits for the consumer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (gnt_vld) state_nx = sel_legal ? EXEC : RESP;
            EXEC: if (cnt == 4'd1) state_nx = RESP;
            RESP: if (rsp_valid && rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Datapath: latch the granted op, count latency, capture and hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            cnt       <= 4'd0;
            alu_op    <= 6'd0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_c     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_res   <= 32'd0;
            rsp_carry <= 1'b0;
            rsp_z     <= 1'b0;
            rsp_n     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        alu_op <= sel_op;
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_c  <= sel_c;
                        rsp_id <= gnt_id;
                        ptr    <= ~gnt_id;
                        cnt    <= 4'(ALU_LAT);
                        if (!sel_legal) begin
                            // ALU operands are loaded anyway but never sampled.
                            rsp_res   <= 32'd0;
                            rsp_carry <= 1'b0;
                            rsp_z     <= 1'b0;
                            rsp_n     <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_res   <= alu_res;
                        rsp_carry <= cur_arith ? alu_cout : 1'b0;
                        rsp_z     <= (alu_res == 32'd0);
                        rsp_n     <= alu_res[31];
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Index 0: ALU_LAT=1 instance, index 1: ALU_LAT=3 instance.
    logic        r0v [2];
    logic        r1v [2];
    logic [5:0]  r0op[2];
    logic [5:0]  r1op[2];
    logic [31:0] r0a [2];
    logic [31:0] r0b [2];
    logic [31:0] r1a [2];
    logic [31:0] r1b [2];
    logic        r0c [2];
    logic        r1c [2];
    logic        r0rdy[2];
    logic        r1rdy[2];
    logic [5:0]  aop [2];
    logic [31:0] aa  [2];
    logic [31:0] ab  [2];
    logic        ac  [2];
    logic [31:0] ares[2];
    logic        acout[2];
    logic        rrdy[2];
    logic        rv  [2];
    logic        rid [2];
    logic [31:0] rres[2];
    logic        rcar[2];
    logic        rz  [2];
    logic        rn  [2];
    logic        rerr[2];

    int   checks = 0;
    int   errors = 0;
    logic ptr_m[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_req_arbiter #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(r0v[g]), .req0_ready(r0rdy[g]), .req0_op(r0op[g]),
            .req0_a(r0a[g]), .req0_b(r0b[g]), .req0_c(r0c[g]),
            .req1_valid(r1v[g]), .req1_ready(r1rdy[g]), .req1_op(r1op[g]),
            .req1_a(r1a[g]), .req1_b(r1b[g]), .req1_c(r1c[g]),
            .alu_op(aop[g]), .alu_a(aa[g]), .alu_b(ab[g]), .alu_c(ac[g]),
            .alu_res(ares[g]), .alu_cout(acout[g]),
            .rsp_valid(rv[g]), .rsp_ready(rrdy[g]), .rsp_id(rid[g]),
            .rsp_res(rres[g]), .rsp_carry(rcar[g]), .rsp_z(rz[g]),
            .rsp_n(rn[g]), .rsp_err(rerr[g])
        );
    end

    // Behavioural ALU: what the datapath should return for an op.
    function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic c,
                                    output logic [31:0] res, output logic cout,
                                    output logic legal);
        logic [32:0] w;
        res = 32'd0; cout = 1'b0; legal = 1'b1;
        case (op)
            6'h10: begin w = {1'b0, a} + {1'b0, b} + 33'(c); res = w[31:0]; cout = w[32]; end
            6'h11: begin w = {1'b0, a} - {1'b0, b} - 33'(c); res = w[31:0]; cout = w[32]; end
            6'h20: res = (a == b) ? 32'd1 : 32'd0;
            6'h30: res = a << b[4:0];
            6'h31: res = a >> b[4:0];
            6'h32: res = 32'($signed(a) >>> b[4:0]);
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic logic [110:0] all_out(input int k);
        return {r0rdy[k], r1rdy[k], aop[k], aa[k], ab[k], ac[k], rv[k], rid[k],
                rres[k], rcar[k], rz[k], rn[k], rerr[k]};
    endfunction

    // Drives one transaction (from a negedge), checks grant, latency and response, then consumes it.
    task automatic run_txn(input int k, input logic v0, input logic v1,
                           input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                           input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                           input int wait_n, input bit keep);
        int lat;
        logic g, c, ecar, legal, arith;
        logic [5:0] op;
        logic [31:0] a, b, eres;
        logic [36:0] exp_rsp, act;
        lat = (k == 0) ? 1 : 3;
        r0v[k] = v0; r0op[k] = op0; r0a[k] = a0; r0b[k] = b0; r0c[k] = c0;
        r1v[k] = v1; r1op[k] = op1; r1a[k] = a1; r1b[k] = b1; r1c[k] = c1;
        #1;
        g = (v0 && v1) ? ptr_m[k] : v1;
        checks++;
        if ({r0rdy[k], r1rdy[k]} !== {~g, g}) begin
            errors++;
            $display("FAIL grant dut%0d: ready0/1=%b%b want %b%b", k, r0rdy[k], r1rdy[k], ~g, g);
        end
        op = g ? op1 : op0; a = g ? a1 : a0; b = g ? b1 : b0; c = g ? c1 : c0;
        ref_alu(op, a, b, c, eres, ecar, legal);
        arith = (op == 6'h10) || (op == 6'h11);
        exp_rsp = {g, eres, ecar, legal && (eres == 32'd0), legal && eres[31], ~legal};
        @(posedge clk);
        ptr_m[k] = ~g;
        @(negedge clk);
        if (!keep) begin r0v[k] = 1'b0; r1v[k] = 1'b0; end
        checks++;
        if ({r0rdy[k], r1rdy[k]} !== 2'b00) begin
            errors++;
            $display("FAIL ready_pulse dut%0d: ready0/1=%b%b want 00", k, r0rdy[k], r1rdy[k]);
        end
        checks++;
        if ({aop[k], aa[k], ab[k], ac[k]} !== {op, a, b, c}) begin
            errors++;
            $display("FAIL alu_regs dut%0d: got %h %h %h %b want %h %h %h %b", k, aop[k], aa[k], ab[k], ac[k], op, a, b, c);
        end
        if (legal) begin
            for (int n = 0; n < lat; n++) begin
                checks++;
                if (rv[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL early_rsp dut%0d: rsp_valid=%b after %0d edges want 0", k, rv[k], n);
                end
                if (n == lat - 1) begin
                    ares[k]  = eres;
                    acout[k] = arith ? ecar : 1'($urandom);
                end else begin
                    ares[k]  = $urandom;
                    acout[k] = 1'($urandom);
                end
                @(negedge clk);
            end
            ares[k] = $urandom;
            acout[k] = 1'($urandom);
        end
        checks++;
        if (rv[k] !== 1'b1) begin
            errors++;
            $display("FAIL rsp_valid dut%0d: got %b want 1", k, rv[k]);
        end
        act = {rid[k], rres[k], rcar[k], rz[k], rn[k], rerr[k]};
        checks++;
        if (act !== exp_rsp) begin
            errors++;
            $display("FAIL rsp_fields dut%0d op=%h: id/res/c/z/n/err=%h want %h", k, op, act, exp_rsp);
        end
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            act = {rid[k], rres[k], rcar[k], rz[k], rn[k], rerr[k]};
            checks++;
            if ({rv[k], act, r0rdy[k], r1rdy[k]} !== {1'b1, exp_rsp, 2'b00}) begin
                errors++;
                $display("FAIL backpressure dut%0d cyc%0d: valid=%b rsp=%h rdy=%b%b want 1 %h 00",
                         k, i, rv[k], act, r0rdy[k], r1rdy[k], exp_rsp);
            end
        end
        rrdy[k] = 1'b1;
        @(negedge clk);
        rrdy[k] = 1'b0;
        checks++;
        if (rv[k] !== 1'b0) begin
            errors++;
            $display("FAIL consume dut%0d: rsp_valid=%b want 0", k, rv[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin r0v[k] = 1'b1; r1v[k] = 1'b1; end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (all_out(k) !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: outputs=%h want 0", k, all_out(k));
            end
            r0v[k] = 1'b0; r1v[k] = 1'b0; ptr_m[k] = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        run_txn(0, 1, 0, 6'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 0, 0);
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++)
            run_txn(0, 1, 1, 6'h11, 32'd5, 32'd7, 1'b0, 6'h32, 32'h8000_0000, 32'd4, 1'b0, 0, i != 3);
    endtask

    task automatic test_backpressure();
        run_txn(0, 1, 1, 6'h10, 32'h7FFF_FFFF, 32'd1, 1'b1, 6'h30, 32'h1, 32'd31, 1'b0, 5, 1);
        r0v[0] = 1'b0; r1v[0] = 1'b0;
    endtask

    task automatic test_illegal();
        run_txn(0, 0, 1, 6'h00, 32'd0, 32'd0, 1'b0, 6'h3F, 32'h1234, 32'h5678, 1'b1, 0, 0);
    endtask

    task automatic test_lat3();
        run_txn(1, 1, 0, 6'h20, 32'h1234, 32'h1234, 1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1, 0);
    endtask

    task automatic test_reset_mid_exec();
        r0v[1] = 1'b1; r0op[1] = 6'h10; r0a[1] = 32'd5; r0b[1] = 32'd7; r0c[1] = 1'b1;
        r1v[1] = 1'b0;
        @(negedge clk);
        r0v[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out(1) !== '0) begin
            errors++;
            $display("FAIL reset_mid_exec: outputs=%h want 0", all_out(1));
        end
        ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rv[1] !== 1'b0) begin
                errors++;
                $display("FAIL dropped_op: rsp_valid=%b at cycle %0d want 0", rv[1], i);
            end
        end
        // Both valid right after reset: pointer must be back at 0.
        run_txn(1, 1, 1, 6'h31, 32'hF000_0000, 32'd8, 1'b0, 6'h10, 32'd1, 32'd2, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] legal_ops [6];
        logic [5:0] o0, o1;
        logic v0, v1;
        legal_ops = '{6'h10, 6'h11, 6'h20, 6'h30, 6'h31, 6'h32};
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 25; t++) begin
                o0 = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 5)] : 6'($urandom);
                o1 = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 5)] : 6'($urandom);
                v0 = 1'($urandom); v1 = 1'($urandom);
                if (!v0 && !v1) v0 = 1'b1;
                run_txn(k, v0, v1,
                        o0, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom, 1'($urandom),
                        o1, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom, 1'($urandom),
                        $urandom_range(0, 2), 0);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            r0v[k] = 1'b0; r1v[k] = 1'b0; r0op[k] = 6'd0; r1op[k] = 6'd0;
            r0a[k] = 32'd0; r0b[k] = 32'd0; r1a[k] = 32'd0; r1b[k] = 32'd0;
            r0c[k] = 1'b0; r1c[k] = 1'b0; ares[k] = 32'd0; acout[k] = 1'b0;
            rrdy[k] = 1'b0; ptr_m[k] = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_illegal();
        test_lat3();
        test_reset_mid_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
